// File: rtl/vga_fb_arbiter.sv
// Framebuffer arbiter: shares one single-port RAM between the display
// fetch path (one cell per 8 pixels) and a handshaked writer port.
// Display fetches always win in IDLE. An in-flight write is never aborted.
module vga_fb_arbiter #(
  parameter int COLS = 80,
  parameter int ROWS = 60,
  parameter int AW   = 13,
  parameter int DW   = 8
) (
  input  logic          iCLK,
  input  logic          iRST_N,
  input  logic [9:0]    iPosX,
  input  logic [9:0]    iPosY,
  input  logic          iVideoOn,
  input  logic          iPixTick,
  input  logic          iWrReq,
  input  logic [AW-1:0] iWrAddr,
  input  logic [DW-1:0] iWrData,
  output logic          oWrAck,
  output logic [AW-1:0] oMemAddr,
  output logic          oMemWe,
  output logic [DW-1:0] oMemWData,
  input  logic [DW-1:0] iMemRData,
  output logic [DW-1:0] oCellData,
  output logic          oCellValid,
  output logic          oFetchMiss
);

  typedef enum logic [1:0] {IDLE, DRD, DWAIT, WR} fbState_t;

  localparam logic [AW-1:0] COLS_W  = AW'(COLS);
  localparam logic [AW:0]   CELLS_W = (AW+1)'(COLS * ROWS);

  fbState_t      state, nxt;
  logic          pend;
  logic [AW-1:0] capAddr;
  logic [AW-1:0] rowIdx, rowBase, fetchAddr;
  logic          trig, issue, inRange;
  logic          unusedPosY;

  // Sub-cell line bits only select the glyph row downstream.
  assign unusedPosY = ^iPosY[2:0];

  assign trig    = iPixTick & iVideoOn & (iPosX[2:0] == 3'd0);
  assign issue   = (state == IDLE) & (trig | pend);
  assign inRange = {1'b0, iWrAddr} < CELLS_W;
  assign rowIdx  = AW'(iPosY[9:3]);

  // Row base as a constant shift-add over the set bits of COLS.
  always_comb begin
    rowBase = '0;
    for (int b = 0; b < AW; b++)
      if (COLS_W[b]) rowBase = rowBase + (rowIdx << b);
  end

  assign fetchAddr = rowBase + AW'(iPosX[9:3]);

  // State register.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) state <= IDLE;
    else         state <= nxt;
  end

  // Next-state: a trigger in the current cycle counts as pending so it
  // beats a simultaneous write request.
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (trig || pend) nxt = DRD;
               else if (iWrReq) nxt = WR;
      DRD:     nxt = DWAIT;
      DWAIT:   nxt = IDLE;
      WR:      nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Pending fetch capture. A trigger arriving while an earlier one is
  // still unissued replaces it and latches the sticky miss flag.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      pend       <= 1'b0;
      capAddr    <= '0;
      oFetchMiss <= 1'b0;
    end else begin
      if (trig && pend) oFetchMiss <= 1'b1;
      if (trig)         capAddr    <= fetchAddr;
      if (issue)        pend       <= 1'b0;
      else if (trig)    pend       <= 1'b1;
    end
  end

  // RAM port outputs are registered from the next state so they line up
  // with the state they belong to; the address holds when the RAM is idle.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      oMemAddr  <= '0;
      oMemWe    <= 1'b0;
      oMemWData <= '0;
      oWrAck    <= 1'b0;
    end else begin
      oWrAck    <= (nxt == WR);
      oMemWe    <= (nxt == WR) && inRange;
      oMemWData <= (nxt == WR) ? iWrData : '0;
      if (nxt == DRD)     oMemAddr <= trig ? fetchAddr : capAddr;
      else if (nxt == WR) oMemAddr <= iWrAddr;
    end
  end

  // Capture RAM read data during DWAIT and flag it for one cycle.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      oCellData  <= '0;
      oCellValid <= 1'b0;
    end else begin
      oCellValid <= (state == DWAIT);
      if (state == DWAIT) oCellData <= iMemRData;
    end
  end

endmodule
